// File: rtl/approx_product_accumulator.sv
// approx_product_accumulator
//   Sums a packet of unsigned 16-bit products from an approximate 8x8
//   multiplier and presents the total, the term count and status flags
//   until the consumer takes them.
//
//   Build option: define APPROX_ACC_SATURATE_EN to clamp the sum at
//   2^ACC_W-1 and raise a sticky sat_flag. Without it the sum wraps
//   modulo 2^ACC_W and sat_flag is tied to 0.
//
//   Ports
//     clk, rst             clock, asynchronous active-high reset
//     in_valid/in_ready    beat handshake; z is the product, in_last closes the packet
//     out_valid/out_ready  result handshake
//     acc_out, term_count  packet sum and number of accumulated beats
//     forced_close         packet closed at MAX_TERMS without in_last
//     sat_flag             saturation happened in this packet
//
//   state | meaning
//   IDLE  | waiting for the first beat; outputs read 0
//   ACCUM | packet open, running sum visible
//   HOLD  | result presented, input stalled until out_ready
module approx_product_accumulator #(
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      z,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] term_count,
  output logic             forced_close,
  output logic             sat_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_TERMS);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             forced_q, forced_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic [ACC_W-1:0] z_ext;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;
  assign z_ext    = {{(ACC_W-16){1'b0}}, z};
  assign cnt_inc  = cnt_q + CNT_W'(1);

`ifdef APPROX_ACC_SATURATE_EN
  logic carry;
  assign {carry, sum} = {1'b0, acc_q} + {1'b0, z_ext};
`else
  assign sum = acc_q + z_ext;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    forced_d = forced_q;
    sat_d    = sat_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d    = z_ext;
          cnt_d    = CNT_W'(1);
          forced_d = 1'b0;
          sat_d    = 1'b0;
          state_d  = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_inc;
`ifdef APPROX_ACC_SATURATE_EN
          if (carry) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = sum;
          end
`else
          acc_d = sum;
`endif
          if (in_last) begin
            state_d = HOLD;
          end else if (cnt_inc == MaxCnt) begin
            state_d  = HOLD;
            forced_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // Clearing on release keeps the outputs at 0 while idle.
        if (out_ready) begin
          state_d  = IDLE;
          acc_d    = '0;
          cnt_d    = '0;
          forced_d = 1'b0;
          sat_d    = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        acc_d    = '0;
        cnt_d    = '0;
        forced_d = 1'b0;
        sat_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      forced_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
      sat_q    <= sat_d;
    end
  end

  assign out_valid    = (state_q == HOLD);
  assign acc_out      = acc_q;
  assign term_count   = cnt_q;
  assign forced_close = forced_q;
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_approx_product_accumulator.sv
// Testbench for approx_product_accumulator: a default-width instance and a
// 17-bit instance share the same stimulus; both are compared against a
// packet-level arithmetic model.
module tb_approx_product_accumulator;

  localparam int ACC_W     = 24;
  localparam int ACC_W_S   = 17;
  localparam int MAX_TERMS = 16;
  localparam int CNT_W     = 5;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, out_ready;
  logic [15:0] z;

  logic               in_ready_a, out_valid_a, forced_a, sat_a;
  logic [ACC_W-1:0]   acc_a;
  logic [CNT_W-1:0]   cnt_a;
  logic               in_ready_b, out_valid_b, forced_b, sat_b;
  logic [ACC_W_S-1:0] acc_b;
  logic [CNT_W-1:0]   cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  approx_product_accumulator #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .z(z),
    .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .acc_out(acc_a), .term_count(cnt_a), .forced_close(forced_a), .sat_flag(sat_a)
  );

  approx_product_accumulator #(.ACC_W(ACC_W_S), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .z(z),
    .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .acc_out(acc_b), .term_count(cnt_b), .forced_close(forced_b), .sat_flag(sat_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sum of the first n beats at width w, with clamp or wrap per build.
  function automatic void ref_sum(input int unsigned vals[$], input int n, input int w,
                                  output longint unsigned acc, output bit sat);
    longint unsigned lim;
    lim = (64'd1 << w) - 1;
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < n; i++) begin
`ifdef APPROX_ACC_SATURATE_EN
      if (acc + vals[i] > lim) begin
        acc = lim;
        sat = 1'b1;
      end else begin
        acc = acc + vals[i];
      end
`else
      acc = (acc + vals[i]) % (lim + 1);
`endif
    end
  endfunction

  task automatic check_all(input string tag, input int unsigned vals[$], input int k,
                           input bit exp_valid, input bit exp_forced);
    longint unsigned ea, eb;
    bit sa, sb;
    ref_sum(vals, k, ACC_W, ea, sa);
    ref_sum(vals, k, ACC_W_S, eb, sb);
    chk({tag, ".acc"},      acc_a, ea);
    chk({tag, ".cnt"},      cnt_a, k);
    chk({tag, ".valid"},    out_valid_a, exp_valid);
    chk({tag, ".ready"},    in_ready_a, !exp_valid);
    chk({tag, ".forced"},   forced_a, exp_forced);
    chk({tag, ".sat"},      sat_a, sa);
    chk({tag, ".acc_s"},    acc_b, eb);
    chk({tag, ".cnt_s"},    cnt_b, k);
    chk({tag, ".valid_s"},  out_valid_b, exp_valid);
    chk({tag, ".forced_s"}, forced_b, exp_forced);
    chk({tag, ".sat_s"},    sat_b, sb);
  endtask

  task automatic run_packet(input string tag, input int unsigned vals[$], input bit use_last,
                            input int hold, input bit gaps);
    int n, closes_at;
    bit forced;
    int unsigned empty[$];
    n = vals.size();
    closes_at = (use_last && n <= MAX_TERMS) ? n : MAX_TERMS;
    forced = !(use_last && n <= MAX_TERMS);
    for (int i = 0; i < closes_at; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          in_valid = 1'b0;
          z        = 16'($urandom);
          in_last  = 1'($urandom);
          @(posedge clk); @(negedge clk);
        end
        in_last = 1'b0;
        if (i > 0) check_all({tag, ".gap"}, vals, i, 1'b0, 1'b0);
      end
      in_valid = 1'b1;
      z        = 16'(vals[i]);
      in_last  = use_last && (i == n - 1);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i < closes_at - 1) check_all({tag, ".accum"}, vals, i + 1, 1'b0, 1'b0);
    end
    check_all({tag, ".hold"}, vals, closes_at, 1'b1, forced);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      z        = 16'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); @(negedge clk);
      check_all({tag, ".stall"}, vals, closes_at, 1'b1, forced);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check_all({tag, ".idle"}, empty, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned q[$];
    int unsigned empty[$];
    int n;
    bit ul;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; z = '0;
    repeat (2) @(negedge clk);
    check_all("reset", empty, 0, 1'b0, 1'b0);
    rst = 1'b0;

    // Three-beat packet; first edge after reset must accept.
    q = '{100, 200, 300};
    run_packet("p600", q, 1'b1, 0, 1'b0);

    q = '{16'hFFFF};
    run_packet("single", q, 1'b1, 0, 1'b0);

    q.delete();
    for (int i = 0; i < MAX_TERMS; i++) q.push_back(16'hFFFF);
    run_packet("forced", q, 1'b0, 1, 1'b0);

    q = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_packet("ovf3", q, 1'b1, 0, 1'b0);

    q = '{5, 6, 9};
    run_packet("stall5", q, 1'b1, 5, 1'b1);

    // in_last on exactly the MAX_TERMS-th beat is a normal close.
    q.delete();
    for (int i = 0; i < MAX_TERMS; i++) q.push_back($urandom_range(0, 65535));
    run_packet("last_at_max", q, 1'b1, 0, 1'b0);

    // Reset in the middle of a packet discards it.
    in_valid = 1'b1; z = 16'd40; @(posedge clk); @(negedge clk);
    z = 16'd50; @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_all("midrst", empty, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    q = '{7};
    run_packet("after_rst", q, 1'b1, 0, 1'b0);

    for (int p = 0; p < 25; p++) begin
      ul = ($urandom_range(0, 3) != 0);
      n  = ul ? int'($urandom_range(1, MAX_TERMS + 3)) : MAX_TERMS;
      q.delete();
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF : $urandom_range(0, 65535));
      run_packet("rand", q, ul, $urandom_range(0, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/approx_product_accumulator.md
APPROX_PRODUCT_ACCUMULATOR -- requirements
Module: approx_product_accumulator

Interface
REQ-001 Parameter ACC_W, default 24: accumulator width in bits; legal range 17..32.
REQ-002 Parameter MAX_TERMS, default 16: maximum products per packet; legal range 2..255.
REQ-003 Parameter CNT_W, default 5: term-counter width; SHALL equal ceil(log2(MAX_TERMS+1)).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  z and in_last carry a valid product beat.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 z  input  16  unsigned 8x8 approximate-multiplier product, treated as an unsigned integer.
REQ-009 in_last  input  1  current beat is the final term of the packet.
REQ-010 out_valid  output  1  acc_out, term_count and the flags hold a completed packet.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 acc_out  output  ACC_W  packet sum.
REQ-013 term_count  output  CNT_W  number of beats accumulated in the packet.
REQ-014 forced_close  output  1  packet was closed by reaching MAX_TERMS without in_last.
REQ-015 sat_flag  output  1  saturation occurred in the packet; constant 0 when saturation is compiled out.

Function
REQ-016 State machine with states IDLE, ACCUM and HOLD.
REQ-017 A beat is accepted in a cycle where in_valid and in_ready are both 1; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-018 IDLE, on accept: acc = zero-extended z, term_count = 1, forced_close = 0, sat_flag = 0; next state is HOLD if in_last is 1, else ACCUM.
REQ-019 ACCUM, on accept: acc = acc + z, term_count incremented; next state is HOLD if in_last is 1 or the new term_count equals MAX_TERMS, else ACCUM.
REQ-020 forced_close SHALL be set to 1 when HOLD is entered because term_count reached MAX_TERMS while in_last was 0.
REQ-021 Without accept, IDLE and ACCUM hold all state; idle gaps inside a packet are legal.
REQ-022 out_valid SHALL be 1 exactly in HOLD; acc_out, term_count, forced_close and sat_flag SHALL stay stable while out_valid is 1.
REQ-023 HOLD with out_ready = 1: next state is IDLE and out_valid is 0 in the following cycle.
REQ-024 There is no same-cycle beat acceptance in HOLD: the packet gap is at least one cycle.
REQ-025 Latency: out_valid SHALL rise on the clock edge that accepts the closing beat, i.e. 1 cycle after that beat is presented.
REQ-026 Arithmetic without saturation: the sum wraps modulo 2^ACC_W.
REQ-027 in_last SHALL be ignored when in_valid is 0.
REQ-028 acc_out and term_count SHALL read 0 in IDLE; in ACCUM they show the running values.

Reset
REQ-029 When rst = 1, the block SHALL immediately, independent of clk, enter IDLE and drive: acc_out 0, term_count 0, out_valid 0, in_ready 1, forced_close 0, sat_flag 0.
REQ-030 A reset during ACCUM or HOLD discards the partial or pending packet; no result SHALL be emitted for it.
REQ-031 After rst deasserts, the first edge with in_valid = 1 SHALL accept a beat.

Configuration
REQ-032 Macro APPROX_ACC_SATURATE_EN.
- Defined: when acc + z exceeds 2^ACC_W - 1, acc is clamped to 2^ACC_W - 1 and sat_flag is set; sat_flag is sticky until the next packet starts.
- Undefined: the sum wraps per REQ-026 and sat_flag is tied to 0.

Verification
REQ-033 Beats 100, 200, 300 (last on 300), out_ready = 1 -> acc_out = 600, term_count = 3, out_valid for 1 cycle, forced_close = 0.
REQ-034 Single beat 0xFFFF with in_last = 1 -> HOLD the next cycle, acc_out = 65535, term_count = 1.
REQ-035 16 beats of 0xFFFF, in_last never set, MAX_TERMS = 16 -> closes on the 16th beat, acc_out = 1048560, term_count = 16, forced_close = 1, in_ready = 0 afterwards.
REQ-036 ACC_W = 17, three beats of 0xFFFF -> with the macro: acc_out = 131071, sat_flag = 1; without it: acc_out = 65533, sat_flag = 0.
REQ-037 Result pending with out_ready held low for 5 cycles, in_valid = 1 -> outputs stable, in_ready = 0, no beat consumed; out_ready high -> IDLE the next cycle, then the next beat is accepted.
REQ-038 rst pulsed after 2 of 4 beats -> all outputs at reset values; a fresh 1-beat packet of value 7 then gives acc_out = 7, term_count = 1.
